// File: rtl/ps2_host_tx_pkg.sv
// Shared constants for the PS/2 host transmitter: FSM encodings, error codes,
// and the time-to-cycles helper used to size every timeout.
package ps2_host_tx_pkg;

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_INHIBIT   = 4'd1;
    localparam logic [3:0] S_REQ       = 4'd2;
    localparam logic [3:0] S_WAIT_DEV  = 4'd3;
    localparam logic [3:0] S_SHIFT     = 4'd4;
    localparam logic [3:0] S_ACK       = 4'd5;
    localparam logic [3:0] S_WAIT_IDLE = 4'd6;
    localparam logic [3:0] S_DONE      = 4'd7;
    localparam logic [3:0] S_ERR       = 4'd8;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_START = 2'b01;
    localparam logic [1:0] ERR_FRAME = 2'b10;
    localparam logic [1:0] ERR_NACK  = 2'b11;

    // per_sec is 1_000_000 for microseconds, 1_000 for milliseconds
    function automatic int to_cyc(input int freq, input int per_sec, input int amount);
        return freq / per_sec * amount;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Pad input conditioner: 2-FF synchroniser, stability filter, edge pulses.
// Shared between the PS/2 transmitter and receiver.
module ps2_line_filter #(
    parameter int FILT_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic line_i,
    output logic filt_o,
    output logic fall_o,
    output logic rise_o
);

    localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    logic [1:0]    sync_q;
    logic          filt_q;
    logic          prev_q;
    logic [CW-1:0] cnt_q;

    // Idle bus is high, so everything resets to 1 to avoid a false edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= 2'b11;
            filt_q <= 1'b1;
            prev_q <= 1'b1;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], line_i};
            prev_q <= filt_q;
            if (sync_q[1] == filt_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(FILT_LEN - 1)) begin
                filt_q <= sync_q[1];
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign filt_o = filt_q;
    assign fall_o = prev_q & ~filt_q;
    assign rise_o = ~prev_q & filt_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, shift the
// frame on the device clock and check the device ACK.
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int clk_freq    = 50000000,
    parameter int inhibit_us  = 100,
    parameter int start_to_ms = 15,
    parameter int frame_to_ms = 2,
    parameter int filt_len    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err,
    output logic [1:0] tx_err_code,
    output logic       rx_hold,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int INHIBIT_CYC = to_cyc(clk_freq, 1000000, inhibit_us);
    localparam int START_CYC   = to_cyc(clk_freq, 1000, start_to_ms);
    localparam int FRAME_CYC   = to_cyc(clk_freq, 1000, frame_to_ms);
    localparam int MAX_A       = (START_CYC > FRAME_CYC) ? START_CYC : FRAME_CYC;
    localparam int MAX_CYC     = (MAX_A > INHIBIT_CYC) ? MAX_A : INHIBIT_CYC;
    localparam int TW          = $clog2(MAX_CYC + 1);

    logic [1:0] pad_in, line_filt, line_fall, line_rise;
    logic       unused_edges;

    assign pad_in = {ps2_data_i, ps2_clk_i};

    for (genvar g = 0; g < 2; g++) begin : g_filt
        ps2_line_filter #(.FILT_LEN(filt_len)) u_filt (
            .clk    (clk),
            .rst    (rst),
            .line_i (pad_in[g]),
            .filt_o (line_filt[g]),
            .fall_o (line_fall[g]),
            .rise_o (line_rise[g])
        );
    end

    assign unused_edges = ^{line_fall[1], line_rise};

    logic          clk_f, data_f, clk_fall;
    assign clk_f    = line_filt[0];
    assign data_f   = line_filt[1];
    assign clk_fall = line_fall[0];

    logic [3:0]    state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [3:0]    bitcnt_q, bitcnt_d;
    logic [9:0]    shreg_q, shreg_d;
    logic          clk_oe_q, clk_oe_d, data_oe_q, data_oe_d;
    logic [1:0]    err_q, err_d;
    logic          frame_to;

    assign frame_to = (tmr_q == TW'(FRAME_CYC - 1));

    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q + 1'b1;
        bitcnt_d  = bitcnt_q;
        shreg_d   = shreg_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        err_d     = err_q;
        case (state_q)
            S_IDLE: begin
                tmr_d = '0;
                if (tx_start) begin
                    shreg_d   = {1'b1, ~^tx_data, tx_data};
                    bitcnt_d  = '0;
                    err_d     = ERR_NONE;
                    clk_oe_d  = 1'b1;
                    data_oe_d = 1'b0;
                    state_d   = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (tmr_q == TW'(INHIBIT_CYC - 1)) begin
                    data_oe_d = 1'b1;
                    state_d   = S_REQ;
                end
            end
            S_REQ: begin
                clk_oe_d = 1'b0;
                tmr_d    = '0;
                state_d  = S_WAIT_DEV;
            end
            S_WAIT_DEV: begin
                if (clk_fall) begin
                    // First device edge also starts the whole-frame timer.
                    data_oe_d = ~shreg_q[0];
                    shreg_d   = {1'b1, shreg_q[9:1]};
                    bitcnt_d  = 4'd1;
                    tmr_d     = '0;
                    state_d   = S_SHIFT;
                end else if (tmr_q == TW'(START_CYC - 1)) begin
                    data_oe_d = 1'b0;
                    err_d     = ERR_START;
                    state_d   = S_ERR;
                end
            end
            S_SHIFT: begin
                if (frame_to) begin
                    data_oe_d = 1'b0;
                    err_d     = ERR_FRAME;
                    state_d   = S_ERR;
                end else if (clk_fall) begin
                    // bitcnt 8 presents parity, 9 the stop bit (release)
                    data_oe_d = ~shreg_q[0];
                    shreg_d   = {1'b1, shreg_q[9:1]};
                    bitcnt_d  = bitcnt_q + 1'b1;
                    if (bitcnt_q == 4'd9) state_d = S_ACK;
                end
            end
            S_ACK: begin
                if (frame_to) begin
                    err_d   = ERR_FRAME;
                    state_d = S_ERR;
                end else if (clk_fall) begin
                    bitcnt_d = 4'd10;
                    if (!data_f) begin
                        state_d = S_WAIT_IDLE;
                    end else begin
                        err_d   = ERR_NACK;
                        state_d = S_ERR;
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (frame_to) begin
                    err_d   = ERR_FRAME;
                    state_d = S_ERR;
                end else if (clk_f && data_f) begin
                    state_d = S_DONE;
                end
            end
            S_DONE, S_ERR: begin
                tmr_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                state_d   = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            tmr_q     <= '0;
            bitcnt_q  <= '0;
            shreg_q   <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            err_q     <= ERR_NONE;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            bitcnt_q  <= bitcnt_d;
            shreg_q   <= shreg_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            err_q     <= err_d;
        end
    end

    assign tx_busy     = (state_q != S_IDLE);
    assign rx_hold     = tx_busy;
    assign tx_done     = (state_q == S_DONE);
    assign tx_err      = (state_q == S_ERR);
    assign tx_err_code = tx_err ? err_q : ERR_NONE;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain pad model, PS/2 device BFM, and a
// result scoreboard fed at tx_start and drained on tx_done/tx_err.
module tb_ps2_host_tx;

    localparam int CLK_FREQ = 1000000;
    localparam int INH      = 100;
    localparam int START    = 15000;
    localparam int FRAME    = 2000;
    localparam int HALF     = 40;

    typedef struct {
        logic [9:0] frame;
        logic [1:0] code;
        bit         cf;
    } exp_t;

    logic       clk, rst;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy, tx_done, tx_err, rx_hold;
    logic [1:0] tx_err_code;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       dev_clk_low, dev_data_low, glitch_low;
    logic       clk_line, data_line;

    assign clk_line  = ~(ps2_clk_oe | dev_clk_low | glitch_low);
    assign data_line = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .clk_freq    (CLK_FREQ),
        .inhibit_us  (100),
        .start_to_ms (15),
        .frame_to_ms (2),
        .filt_len    (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .tx_err      (tx_err),
        .tx_err_code (tx_err_code),
        .rx_hold     (rx_hold),
        .ps2_clk_i   (clk_line),
        .ps2_data_i  (data_line),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    exp_t       exp_q[$];
    int         n_chk = 0, n_err = 0, n_res = 0;
    int         cyc = 0, start_cyc = 0, fall_cyc = 0, res_cyc = 0;
    int         dev_idx = 0, low_run = 0, last_inh = 0;
    bit         req_seen = 0, dev_abort = 0;
    logic [9:0] dev_frame = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    function automatic logic odd_par(input logic [7:0] d);
        int ones = 0;
        for (int i = 0; i < 8; i++) if (d[i]) ones++;
        return (ones % 2 == 0);
    endfunction

    // Inhibit length and request-to-send observation
    always @(negedge clk) begin
        if (ps2_clk_oe) low_run <= low_run + 1;
        else begin
            if (low_run > 0) last_inh <= low_run;
            low_run <= 0;
        end
        if (ps2_clk_oe && ps2_data_oe) req_seen <= 1'b1;
    end

    // Scoreboard drain
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst && (tx_done || tx_err)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", {tx_done, tx_err}, 2'b00);
            end else begin
                e = exp_q.pop_front();
                chk("result", {tx_done, tx_err, tx_err_code},
                    {e.code == 2'b00, e.code != 2'b00, e.code});
                chk("busy_at_end", {tx_busy, rx_hold}, 2'b11);
                if (e.cf) chk("frame", dev_frame, e.frame);
            end
            res_cyc <= cyc;
            n_res   <= n_res + 1;
        end
    end

    task automatic start_tx(input logic [7:0] d, input logic [1:0] code, input bit cf);
        int n = 0;
        while (tx_busy && n < 30000) begin @(negedge clk); n++; end
        chk("idle_before_start", tx_busy, 1'b0);
        exp_q.push_back('{frame: {1'b1, odd_par(d), d}, code: code, cf: cf});
        tx_data   = d;
        tx_start  = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        tx_start = 1'b0;
        chk("busy_on_start", tx_busy, 1'b1);
    endtask

    task automatic wait_res(input int target, input int lim);
        int n = 0;
        while (n_res < target && n < lim) begin @(negedge clk); n++; end
        chk("result_seen", n_res >= target, 1'b1);
    endtask

    task automatic idle_chk(input string tag);
        @(negedge clk);
        chk(tag, {tx_busy, ps2_clk_oe, ps2_data_oe}, 3'b000);
    endtask

    // Device: waits for RTS, clocks nclk edges, samples on rise, drives ACK.
    task automatic dev_run(input int nclk, input bit ack_low, input bit glitch);
        int n = 0;
        bit seen_low = 0;
        dev_frame = '0;
        dev_idx   = 0;
        while (n < 2000 && !dev_abort && !(seen_low && clk_line && !data_line)) begin
            if (!clk_line) seen_low = 1;
            @(negedge clk);
            n++;
        end
        chk("dev_saw_rts", n < 2000, 1'b1);
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < nclk && !dev_abort; i++) begin
            dev_idx = i;
            if (i == 0) fall_cyc = cyc;
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            if (i < 10) dev_frame[i] = data_line;
            dev_clk_low = 1'b0;
            if (i == 9) dev_data_low = ack_low;
            if (glitch && i == 4) begin
                repeat (15) @(negedge clk);
                glitch_low = 1'b1;
                repeat (5) @(negedge clk);
                glitch_low = 1'b0;
                repeat (HALF - 20) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
        end
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout: cycles=%0d", cyc);
        $fatal(1);
    end

    initial begin
        rst          = 1'b1;
        tx_data      = 8'h00;
        tx_start     = 1'b0;
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        glitch_low   = 1'b0;
        #1 rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("reset_outputs",
            {tx_busy, tx_done, tx_err, tx_err_code, rx_hold, ps2_clk_oe, ps2_data_oe}, 8'h00);
        rst = 1'b1;
        repeat (20) @(negedge clk);

        // 1: 0xF4 with ACK
        start_tx(8'hF4, 2'b00, 1'b1);
        dev_run(11, 1'b1, 1'b0);
        wait_res(1, 500);
        chk("inhibit_len", last_inh >= INH, 1'b1);
        chk("req_seen", req_seen, 1'b1);
        chk("f4_bits", dev_frame, 10'b1_0_1111_0100);
        idle_chk("idle_after_f4");

        // 2: back-to-back 0xED, 0x00
        start_tx(8'hED, 2'b00, 1'b1);
        dev_run(11, 1'b1, 1'b0);
        wait_res(2, 500);
        start_tx(8'h00, 2'b00, 1'b1);
        dev_run(11, 1'b1, 1'b0);
        wait_res(3, 500);
        chk("par_00", dev_frame[8], 1'b1);

        // 3: device never clocks
        start_tx(8'h55, 2'b01, 1'b0);
        wait_res(4, 20000);
        chk("start_to_window", (res_cyc - start_cyc >= START) &&
            (res_cyc - start_cyc <= START + INH + 40), 1'b1);
        idle_chk("idle_after_start_to");

        // 4a: device stops after 5 clocks
        start_tx(8'h12, 2'b10, 1'b0);
        dev_run(5, 1'b1, 1'b0);
        wait_res(5, 3000);
        chk("frame_to_window", (res_cyc - fall_cyc >= FRAME) &&
            (res_cyc - fall_cyc <= FRAME + 40), 1'b1);
        idle_chk("idle_after_frame_to");

        // 4b: device omits ACK
        start_tx(8'h9C, 2'b11, 1'b1);
        dev_run(11, 1'b0, 1'b0);
        wait_res(6, 500);
        idle_chk("idle_after_nack");

        // 5: reset mid-SHIFT, then 0x01 completes
        dev_abort = 1'b0;
        start_tx(8'h00, 2'b00, 1'b0);
        fork
            dev_run(11, 1'b1, 1'b0);
            begin
                int n = 0;
                while (dev_idx < 4 && n < 5000) begin @(negedge clk); n++; end
                chk("reached_shift", ps2_data_oe, 1'b1);
                #2 rst = 1'b0;
                #1;
                chk("rst_async_lines", {ps2_clk_oe, ps2_data_oe, tx_busy}, 3'b000);
                exp_q.delete();
                dev_abort = 1'b1;
                repeat (5) @(negedge clk);
                rst = 1'b1;
            end
        join
        dev_abort = 1'b0;
        repeat (20) @(negedge clk);
        start_tx(8'h01, 2'b00, 1'b1);
        dev_run(11, 1'b1, 1'b0);
        wait_res(7, 500);

        // 6: clock glitches and a start request while busy
        start_tx(8'hA5, 2'b00, 1'b1);
        fork
            dev_run(11, 1'b1, 1'b1);
            begin
                repeat (400) @(negedge clk);
                chk("busy_when_poke", tx_busy, 1'b1);
                tx_data  = 8'h3C;
                tx_start = 1'b1;
                @(negedge clk);
                tx_start = 1'b0;
            end
        join
        wait_res(8, 500);
        repeat (200) @(negedge clk);
        chk("no_extra_tx", {tx_busy, ps2_clk_oe}, 2'b00);
        chk("results_total", n_res, 8);
        chk("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
